// File: rtl/double_dabble_serial_if.sv
// double_dabble_serial_if: operand/result handshake bundle for the serial
// binary-to-BCD converter. The master side supplies operands and consumes
// results; the slave side is the converter itself.
interface double_dabble_serial_if #(
  parameter int Input_Bit_Width = 8
) ();

  localparam int Digit_Count = (Input_Bit_Width + 2) / 3;

  logic [Input_Bit_Width-1:0] in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [Digit_Count*4-1:0]   out_bcd;
  logic                       out_sign;
  logic                       out_valid;
  logic                       out_ready;
  logic                       busy;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_bcd,
    input  out_sign,
    input  out_valid,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_bcd,
    output out_sign,
    output out_valid,
    output busy
  );

endinterface

// File: rtl/double_dabble_serial.sv
// double_dabble_serial: multi-cycle binary-to-BCD converter using the
// shift-add-3 (double dabble) algorithm, Bits_Per_Cycle bits per enabled clock.
// Optional feature macro: DOUBLE_DABBLE_SIGNED_EN -- when defined, in_data is
// two's complement, its magnitude is converted and the sign is reported on
// out_sign; when undefined, in_data is unsigned and out_sign is tied low.
module double_dabble_serial #(
  parameter int Input_Bit_Width = 8,
  parameter int Bits_Per_Cycle  = 1
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic                  clk_en,
  double_dabble_serial_if.slave bus
);

  localparam int Digit_Count = (Input_Bit_Width + 2) / 3;
  localparam int Step_Count  = Input_Bit_Width / Bits_Per_Cycle;
  localparam int AccWidth    = Digit_Count * 4;
  localparam int CountWidth  = (Step_Count > 1) ? $clog2(Step_Count) : 1;
  localparam logic [CountWidth-1:0] CountLoad = CountWidth'(Step_Count - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                     r_state;
  logic [Input_Bit_Width-1:0] r_operand;
  logic [AccWidth-1:0]        r_acc;
  logic [CountWidth-1:0]      r_count;
  logic [AccWidth-1:0]        r_outBcd;
  logic                       r_inReady;
  logic                       r_outValid;
  logic                       r_busy;

  logic [Input_Bit_Width-1:0] w_capOperand;
  logic [AccWidth-1:0]        w_stepAcc;
  logic [Input_Bit_Width-1:0] w_stepOp;

`ifdef DOUBLE_DABBLE_SIGNED_EN
  logic r_sign;
  logic r_outSign;
  logic w_capSign;

  // Capture the magnitude of a two's complement operand; the most negative
  // value wraps to itself, which is exactly its unsigned magnitude.
  always_comb begin
    w_capSign    = bus.in_data[Input_Bit_Width-1];
    w_capOperand = bus.in_data;
    if (w_capSign) begin
      w_capOperand = ~bus.in_data + 1'b1;
    end
  end

  assign bus.out_sign = r_outSign;
`else
  assign w_capOperand = bus.in_data;
  assign bus.out_sign = 1'b0;
`endif

  // One conversion step: Bits_Per_Cycle rounds of add-3 correction on every
  // digit followed by a 1-bit left shift of {accumulator, operand}.
  always_comb begin
    w_stepAcc = r_acc;
    w_stepOp  = r_operand;
    for (int b = 0; b < Bits_Per_Cycle; b++) begin
      for (int d = 0; d < Digit_Count; d++) begin
        if (w_stepAcc[d*4 +: 4] >= 4'd5) begin
          w_stepAcc[d*4 +: 4] = w_stepAcc[d*4 +: 4] + 4'd3;
        end
      end
      w_stepAcc = {w_stepAcc[AccWidth-2:0], w_stepOp[Input_Bit_Width-1]};
      w_stepOp  = {w_stepOp[Input_Bit_Width-2:0], 1'b0};
    end
  end

  // Control FSM plus datapath registers; every move is gated by clk_en and
  // the handshake outputs are registered decodes of the state.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state    <= IDLE;
      r_operand  <= '0;
      r_acc      <= '0;
      r_count    <= '0;
      r_outBcd   <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
`ifdef DOUBLE_DABBLE_SIGNED_EN
      r_sign     <= 1'b0;
      r_outSign  <= 1'b0;
`endif
    end else if (clk_en) begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_inReady) begin
            r_operand <= w_capOperand;
            r_acc     <= '0;
            r_count   <= CountLoad;
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= CONVERT;
`ifdef DOUBLE_DABBLE_SIGNED_EN
            r_sign    <= w_capSign;
`endif
          end
        end

        CONVERT: begin
          r_acc     <= w_stepAcc;
          r_operand <= w_stepOp;
          if (r_count == '0) begin
            r_outBcd   <= w_stepAcc;
            r_outValid <= 1'b1;
            r_state    <= DONE;
`ifdef DOUBLE_DABBLE_SIGNED_EN
            r_outSign  <= r_sign;
`endif
          end else begin
            r_count <= r_count - 1'b1;
          end
        end

        DONE: begin
          if (bus.out_ready && r_outValid) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end

        default: begin
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.busy      = r_busy;
  assign bus.out_bcd   = r_outBcd;

endmodule
